// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_pkg
// Purpose : Shared types and constants for the SAP-2 multi-byte instruction
//           register: FSM state encoding, instruction length constants and
//           a helper that sizes the operand bus.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } fetch_state_t;

  // SAP-2 instruction lengths as reported by the opcode decoder.
  localparam int LEN_1 = 1;
  localparam int LEN_2 = 2;
  localparam int LEN_3 = 3;

  // Operand bus width. A single-byte machine has no operands; the bus is
  // then a single bit tied to zero so the port stays legal.
  function automatic int operand_bits(input int width, input int max_bytes);
    return (max_bytes > 1) ? (max_bytes - 1) * width : 1;
  endfunction

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_register_register_en.sv
`default_nettype none
// ============================================================================
// Module  : register_en
// Purpose : WIDTH-bit D register with asynchronous active-high reset to zero
//           and a synchronous load enable.
// Ports   : clk (in)  - rising-edge clock
//           rst (in)  - asynchronous active-high reset
//           en  (in)  - load enable
//           d   (in)  - WIDTH-bit data
//           q   (out) - WIDTH-bit registered value
// Rev     : 1.0 - initial release
// ============================================================================
module register_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register_en
`default_nettype wire

// File: rtl/instruction_fetch_register.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_register
// Purpose : Multi-byte instruction register for the SAP-2 datapath. Captures
//           an opcode byte, collects the remaining operand bytes across load
//           strobes and presents the whole instruction to the controller
//           with a valid/acknowledge handshake. Tracks length, supports
//           flush and reports a sticky error.
// Ports   : iClk         (in)  clock, rising edge
//           iReset       (in)  asynchronous active-high reset
//           iData        (in)  byte from the W-bus
//           iLoad        (in)  byte strobe
//           iLen         (in)  decoder length, sampled with the opcode
//           iAck         (in)  controller consumed the held instruction
//           iFlush       (in)  abort partial/held instruction
//           oInstruction (out) opcode byte
//           oOperand     (out) operand bytes, first operand in low byte
//           oLen         (out) accepted length
//           oValid       (out) complete instruction held
//           oBusy        (out) operand collection in progress
//           oError       (out) sticky illegal-length / overrun flag
// Rev     : 1.0 - initial release
// ============================================================================
module instruction_fetch_register
  import instruction_fetch_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BYTES = 3,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                                       iClk,
  input  logic                                       iReset,
  input  logic [WIDTH-1:0]                           iData,
  input  logic                                       iLoad,
  input  logic [LEN_W-1:0]                           iLen,
  input  logic                                       iAck,
  input  logic                                       iFlush,
  output logic [WIDTH-1:0]                           oInstruction,
  output logic [operand_bits(WIDTH, MAX_BYTES)-1:0]  oOperand,
  output logic [LEN_W-1:0]                           oLen,
  output logic                                       oValid,
  output logic                                       oBusy,
  output logic                                       oError
);

  fetch_state_t     state, next_state;
  logic [LEN_W-1:0] idx, idx_next;
  logic             accept;     // iData is taken as a new opcode this cycle
  logic             write_op;   // iData is taken as operand byte[idx]
  logic             set_err;
  logic             len_bad;
  logic [LEN_W-1:0] eff_len;

  // Out-of-range decoder lengths fall back to the longest instruction so the
  // sequencer still sees a well-formed (if flagged) fetch.
  assign len_bad = (iLen == '0) || (iLen > LEN_W'(MAX_BYTES));
  assign eff_len = len_bad ? LEN_W'(MAX_BYTES) : iLen;

  always_comb begin
    next_state = state;
    idx_next   = idx;
    accept     = 1'b0;
    write_op   = 1'b0;
    set_err    = 1'b0;

    if (iFlush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iLoad) accept = 1'b1;
        end
        ST_COLLECT: begin
          if (iLoad) begin
            write_op = 1'b1;
            idx_next = idx + LEN_W'(1);
            // idx names the byte being written now; the last operand is L-2.
            if (idx == oLen - LEN_W'(2)) next_state = ST_READY;
          end
        end
        ST_READY: begin
          if (iLoad && iAck)  accept     = 1'b1;
          else if (iLoad)     set_err    = 1'b1;  // overrun: byte dropped
          else if (iAck)      next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase

      if (accept) begin
        set_err    = len_bad;
        idx_next   = '0;
        next_state = (eff_len == LEN_W'(1)) ? ST_READY : ST_COLLECT;
      end
    end
  end

  // Valid/busy are registered decodes of the next state so they change in
  // step with the state register and never see input glitches.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      oLen   <= '0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
      oError <= 1'b0;
    end else begin
      state  <= next_state;
      idx    <= idx_next;
      oValid <= (next_state == ST_READY);
      oBusy  <= (next_state == ST_COLLECT);
      oError <= oError | set_err;
      if (accept) oLen <= eff_len;
    end
  end

  register_en #(.WIDTH(WIDTH)) u_opcode (
    .clk (iClk),
    .rst (iReset),
    .en  (accept),
    .d   (iData),
    .q   (oInstruction)
  );

  generate
    if (MAX_BYTES > 1) begin : g_operands
      for (genvar k = 0; k < MAX_BYTES - 1; k++) begin : g_byte
        // A new opcode clears every operand byte so short instructions
        // present zeros in the unused upper bytes.
        register_en #(.WIDTH(WIDTH)) u_operand (
          .clk (iClk),
          .rst (iReset),
          .en  (accept | (write_op && (idx == LEN_W'(k)))),
          .d   (accept ? '0 : iData),
          .q   (oOperand[k*WIDTH +: WIDTH])
        );
      end
    end else begin : g_no_operands
      assign oOperand = '0;
    end
  endgenerate

endmodule : instruction_fetch_register
`default_nettype wire

// File: tb/tb_instruction_fetch_register.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch_register
// Purpose : Self-checking bench for instruction_fetch_register (WIDTH=8,
//           MAX_BYTES=3) with directed scenarios and a randomized run
//           compared against a transaction-level model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_register;
  import instruction_fetch_pkg::*;

  logic        iClk = 1'b0;
  logic        iReset;
  logic [7:0]  iData;
  logic        iLoad;
  logic [1:0]  iLen;
  logic        iAck;
  logic        iFlush;
  logic [7:0]  oInstruction;
  logic [15:0] oOperand;
  logic [1:0]  oLen;
  logic        oValid;
  logic        oBusy;
  logic        oError;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: what the controller should see, tracked as an instruction record.
  logic [7:0] m_instr;
  logic [7:0] m_ops [0:1];
  logic [1:0] m_len;
  logic       m_valid, m_busy, m_err;
  int         m_got;

  instruction_fetch_register #(.WIDTH(8), .MAX_BYTES(3)) dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iData        (iData),
    .iLoad        (iLoad),
    .iLen         (iLen),
    .iAck         (iAck),
    .iFlush       (iFlush),
    .oInstruction (oInstruction),
    .oOperand     (oOperand),
    .oLen         (oLen),
    .oValid       (oValid),
    .oBusy        (oBusy),
    .oError       (oError)
  );

  always #5 iClk = ~iClk;

  function automatic logic [28:0] got_vec();
    return {oInstruction, oOperand, oLen, oValid, oBusy, oError};
  endfunction

  function automatic logic [28:0] exp_vec();
    return {m_instr, m_ops[1], m_ops[0], m_len, m_valid, m_busy, m_err};
  endfunction

  task automatic model_reset();
    m_instr = 8'h00; m_ops[0] = 8'h00; m_ops[1] = 8'h00;
    m_len = 2'd0; m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_got = 0;
  endtask

  task automatic model_opcode(input logic [7:0] d, input logic [1:0] len);
    int l;
    l = (len == 0 || len > 3) ? 3 : int'(len);
    if (len == 0 || len > 3) m_err = 1'b1;
    m_instr = d; m_ops[0] = 8'h00; m_ops[1] = 8'h00;
    m_len = 2'(l); m_got = 0;
    m_valid = (l == 1);
    m_busy  = (l != 1);
  endtask

  task automatic model_step(input logic ld, input logic [7:0] d,
                            input logic [1:0] len, input logic ack,
                            input logic fl);
    if (fl) begin
      m_valid = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (ld) begin
        m_ops[m_got] = d;
        m_got++;
        if (m_got == int'(m_len) - 1) begin
          m_busy = 1'b0; m_valid = 1'b1;
        end
      end
    end else if (m_valid) begin
      if (ld && ack)  model_opcode(d, len);
      else if (ld)    m_err = 1'b1;
      else if (ack)   m_valid = 1'b0;
    end else if (ld) begin
      model_opcode(d, len);
    end
  endtask

  task automatic cycle(input logic ld, input logic [7:0] d, input logic [1:0] len,
                       input logic ack, input logic fl);
    iLoad = ld; iData = d; iLen = len; iAck = ack; iFlush = fl;
    @(posedge iClk);
    model_step(ld, d, len, ack, fl);
    #1;
    iLoad = 1'b0; iAck = 1'b0; iFlush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iReset = 1'b1;
    model_reset();
    @(negedge iClk);
    iReset = 1'b0;
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (got_vec() !== 29'h0) $display("FAIL reset_values got=%h want=%h", got_vec(), 29'h0);
    else n_pass++;
    // Reset in the middle of collecting a 3-byte instruction.
    cycle(1'b1, 8'h3A, 2'(LEN_3), 1'b0, 1'b0);
    n_checks++;
    if (oBusy !== 1'b1 || oInstruction !== 8'h3A)
      $display("FAIL collect_before_reset got busy=%b instr=%h want busy=1 instr=3a", oBusy, oInstruction);
    else n_pass++;
    iReset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (got_vec() !== 29'h0) $display("FAIL async_reset got=%h want=%h", got_vec(), 29'h0);
    else n_pass++;
    #2 iReset = 1'b0;
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (got_vec() !== exp_vec()) $display("FAIL idle_after_reset got=%h want=%h", got_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_one_byte();
    cycle(1'b1, 8'h80, 2'(LEN_1), 1'b0, 1'b0);
    n_checks++;
    if ({oValid, oBusy, oInstruction, oOperand, oLen} !== {1'b1, 1'b0, 8'h80, 16'h0000, 2'd1})
      $display("FAIL one_byte got v=%b b=%b i=%h o=%h l=%0d want v=1 b=0 i=80 o=0000 l=1",
               oValid, oBusy, oInstruction, oOperand, oLen);
    else n_pass++;
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    n_checks++;
    if (oValid !== 1'b0 || got_vec() !== exp_vec())
      $display("FAIL one_byte_ack got=%h want=%h", got_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic ok;
    ok = 1'b1;
    cycle(1'b1, 8'h32, 2'(LEN_3), 1'b0, 1'b0);
    if (oBusy !== 1'b1 || oValid !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 8'hFF, 2'd0, 1'b0, 1'b0);
      if (oBusy !== 1'b1 || oValid !== 1'b0) ok = 1'b0;
    end
    cycle(1'b1, 8'h34, 2'd0, 1'b0, 1'b0);
    if (oBusy !== 1'b1 || oValid !== 1'b0) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL gaps_busy got busy=%b valid=%b want busy=1 valid=0 throughout", oBusy, oValid);
    else n_pass++;
    cycle(1'b1, 8'h12, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({oValid, oBusy, oInstruction, oOperand, oLen} !== {1'b1, 1'b0, 8'h32, 16'h1234, 2'd3})
      $display("FAIL gaps_done got v=%b b=%b i=%h o=%h l=%0d want v=1 b=0 i=32 o=1234 l=3",
               oValid, oBusy, oInstruction, oOperand, oLen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 8'h3E, 2'(LEN_2), 1'b1, 1'b0);
    n_checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b1 || oInstruction !== 8'h3E || oOperand !== 16'h0)
      $display("FAIL b2b_start got v=%b b=%b i=%h o=%h want v=0 b=1 i=3e o=0000",
               oValid, oBusy, oInstruction, oOperand);
    else n_pass++;
    cycle(1'b1, 8'h55, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (oValid !== 1'b1 || oOperand !== 16'h0055 || oLen !== 2'd2)
      $display("FAIL b2b_done got v=%b o=%h l=%0d want v=1 o=0055 l=2", oValid, oOperand, oLen);
    else n_pass++;
    // Back-to-back into a 1-byte instruction keeps oValid high.
    cycle(1'b1, 8'h76, 2'(LEN_1), 1'b1, 1'b0);
    n_checks++;
    if (oValid !== 1'b1 || oInstruction !== 8'h76 || oOperand !== 16'h0 || oLen !== 2'd1)
      $display("FAIL b2b_short got v=%b i=%h o=%h l=%0d want v=1 i=76 o=0000 l=1",
               oValid, oInstruction, oOperand, oLen);
    else n_pass++;
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic test_errors();
    cycle(1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (oLen !== 2'd3 || oError !== 1'b1 || oBusy !== 1'b1)
      $display("FAIL len_zero got l=%0d e=%b b=%b want l=3 e=1 b=1", oLen, oError, oBusy);
    else n_pass++;
    cycle(1'b1, 8'hAA, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'hCC, 2'(LEN_1), 1'b0, 1'b0);
    n_checks++;
    if ({oValid, oInstruction, oOperand, oLen, oError} !== {1'b1, 8'h11, 16'hBBAA, 2'd3, 1'b1})
      $display("FAIL overrun got v=%b i=%h o=%h l=%0d e=%b want v=1 i=11 o=bbaa l=3 e=1",
               oValid, oInstruction, oOperand, oLen, oError);
    else n_pass++;
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    n_checks++;
    if (oError !== 1'b1) $display("FAIL err_sticky got e=%b want e=1", oError);
    else n_pass++;
    do_reset();
    n_checks++;
    if (oError !== 1'b0) $display("FAIL err_cleared got e=%b want e=0", oError);
    else n_pass++;
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'h3A, 2'(LEN_3), 1'b0, 1'b0);
    cycle(1'b1, 8'h01, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if ({oValid, oBusy, oInstruction, oOperand, oLen, oError} !== {1'b0, 1'b0, 8'h3A, 16'h0001, 2'd3, 1'b0})
      $display("FAIL flush got v=%b b=%b i=%h o=%h l=%0d e=%b want v=0 b=0 i=3a o=0001 l=3 e=0",
               oValid, oBusy, oInstruction, oOperand, oLen, oError);
    else n_pass++;
    // A following byte starts a fresh instruction, not a continued one.
    cycle(1'b1, 8'h80, 2'(LEN_1), 1'b0, 1'b0);
    n_checks++;
    if (oValid !== 1'b1 || oInstruction !== 8'h80 || oOperand !== 16'h0)
      $display("FAIL after_flush got v=%b i=%h o=%h want v=1 i=80 o=0000", oValid, oInstruction, oOperand);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 6), 8'($urandom), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        if (errs < 10) $display("FAIL random_cycle_%0d got=%h want=%h", i, got_vec(), exp_vec());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    iReset = 1'b0; iData = 8'h00; iLoad = 1'b0; iLen = 2'd0; iAck = 1'b0; iFlush = 1'b0;
    model_reset();
    test_reset();
    test_one_byte();
    test_gaps();
    test_back_to_back();
    test_errors();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instruction_fetch_register
`default_nettype wire
